// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the rPLL dynamic-divider sequencer.
package pll_ctrl_pkg;

    localparam int SEL_W = 6;

    typedef enum logic [2:0] {
        RST,
        WAIT,
        STABLE,
        RUN,
        GATE,
        FAIL
    } pll_state_t;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd1;
    localparam logic [1:0] ERR_LOCK_LOSS = 2'd2;
    localparam logic [1:0] ERR_FAIL      = 2'd3;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Two-flop synchronizer for the asynchronous PLL lock, plus a saturating
// counter of consecutive synced-lock cycles while enabled.
module pll_lock_filter #(
    parameter int STABLE_CYCLES = 256,
    parameter int CNT_W         = 13
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_lock,
    input  logic i_en,
    output logic o_lock_s,
    output logic o_stable_done
);

    localparam logic [CNT_W-1:0] CNT_SAT  = '1;
    localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'(STABLE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_lock;
            r_sync2 <= r_sync1;
            if (!i_en || !r_sync2) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_SAT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_lock_s      = r_sync2;
    // Asserted on the STABLE_CYCLES-th consecutive locked cycle
    assign o_stable_done = i_en && r_sync2 && (r_cnt == DONE_CNT);

endmodule

// File: rtl/pll_dyn_ctrl.sv
// rPLL reset/lock sequencer with runtime IDSEL/FBDSEL/ODSEL reconfiguration.
// Optional PLL_DYN_CTRL_STATS_EN adds relock_cnt and last_err outputs.
module pll_dyn_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int               RST_CYCLES    = 16,
    parameter int               LOCK_TIMEOUT  = 4096,
    parameter int               STABLE_CYCLES = 256,
    parameter int               GATE_CYCLES   = 8,
    parameter int               MAX_RETRY     = 3,
    parameter logic [SEL_W-1:0] DEF_IDSEL     = 6'd0,
    parameter logic [SEL_W-1:0] DEF_FBDSEL    = 6'd0,
    parameter logic [SEL_W-1:0] DEF_ODSEL     = 6'd0
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_idsel,
    input  logic [SEL_W-1:0] req_fbdsel,
    input  logic [SEL_W-1:0] req_odsel,
    input  logic             pll_lock,
    output logic             pll_reset,
    output logic             pll_reset_p,
    output logic [SEL_W-1:0] idsel,
    output logic [SEL_W-1:0] fbdsel,
    output logic [SEL_W-1:0] odsel,
    output logic             locked,
    output logic             user_rst_n,
    output logic             busy,
    output logic             fail
`ifdef PLL_DYN_CTRL_STATS_EN
    ,
    output logic [7:0]       relock_cnt,
    output logic [1:0]       last_err
`endif
);

    localparam int CNT_MAX = max_of(max_of(max_of(RST_CYCLES, LOCK_TIMEOUT),
                                           max_of(STABLE_CYCLES, GATE_CYCLES)), MAX_RETRY);
    localparam int CW = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] CNT_SAT = '1;

    pll_state_t       r_state;
    pll_state_t       w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    r_wait_cnt;
    logic [CW-1:0]    r_retry;
    logic [SEL_W-1:0] r_cap_idsel, r_cap_fbdsel, r_cap_odsel;
    logic [SEL_W-1:0] r_idsel, r_fbdsel, r_odsel;
    logic             r_pll_reset, r_locked, r_user_rst_n, r_busy, r_fail;
    logic             w_lock_s, w_stable_done, w_req_ready, w_accept;
    logic             w_timeout, w_lock_loss;

    pll_lock_filter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CW)
    ) u_lock_filter (
        .clk           (clkin),
        .rst_n         (rst_n),
        .i_lock        (pll_lock),
        .i_en          (r_state == STABLE),
        .o_lock_s      (w_lock_s),
        .o_stable_done (w_stable_done)
    );

    assign w_req_ready = ((r_state == RUN) && w_lock_s) || (r_state == FAIL);
    assign w_accept    = req_valid && w_req_ready;

    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        w_lock_loss  = 1'b0;
        case (r_state)
            RST:    if (r_cnt == CW'(RST_CYCLES - 1)) w_state_next = WAIT;
            WAIT: begin
                if (w_lock_s) begin
                    w_state_next = STABLE;
                end else if (r_wait_cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = (r_retry < CW'(MAX_RETRY)) ? RST : FAIL;
                end
            end
            STABLE: begin
                if (!w_lock_s)          w_state_next = WAIT;
                else if (w_stable_done) w_state_next = RUN;
            end
            RUN: begin
                // Lock loss wins; ready is already low when lock_s is low
                if (!w_lock_s) begin
                    w_lock_loss  = 1'b1;
                    w_state_next = RST;
                end else if (w_accept) begin
                    w_state_next = GATE;
                end
            end
            GATE:   if (r_cnt == CW'(GATE_CYCLES - 1)) w_state_next = RST;
            FAIL:   if (w_accept) w_state_next = RST;
            default: w_state_next = RST;
        endcase
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RST;
            r_cnt        <= '0;
            r_wait_cnt   <= '0;
            r_retry      <= '0;
            r_cap_idsel  <= DEF_IDSEL;
            r_cap_fbdsel <= DEF_FBDSEL;
            r_cap_odsel  <= DEF_ODSEL;
            r_idsel      <= DEF_IDSEL;
            r_fbdsel     <= DEF_FBDSEL;
            r_odsel      <= DEF_ODSEL;
            r_pll_reset  <= 1'b1;
            r_locked     <= 1'b0;
            r_user_rst_n <= 1'b0;
            r_busy       <= 1'b1;
            r_fail       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state)  r_cnt <= '0;
            else if (r_cnt != CNT_SAT)    r_cnt <= r_cnt + CW'(1);
            // WAIT budget survives STABLE->WAIT bounces; only RST restarts it
            if (r_state == RST)
                r_wait_cnt <= '0;
            else if ((r_state == WAIT) && (r_wait_cnt != CNT_SAT))
                r_wait_cnt <= r_wait_cnt + CW'(1);
            if (w_state_next == RUN)
                r_retry <= '0;
            else if ((r_state == FAIL) && w_accept)
                r_retry <= '0;
            else if (w_timeout && (r_retry < CW'(MAX_RETRY)))
                r_retry <= r_retry + CW'(1);
            if ((r_state == RUN) && w_accept) begin
                r_cap_idsel  <= req_idsel;
                r_cap_fbdsel <= req_fbdsel;
                r_cap_odsel  <= req_odsel;
            end
            if ((r_state == GATE) && (w_state_next == RST)) begin
                r_idsel  <= r_cap_idsel;
                r_fbdsel <= r_cap_fbdsel;
                r_odsel  <= r_cap_odsel;
            end else if ((r_state == FAIL) && w_accept) begin
                r_idsel  <= req_idsel;
                r_fbdsel <= req_fbdsel;
                r_odsel  <= req_odsel;
            end
            r_pll_reset  <= (w_state_next == RST) || (w_state_next == FAIL);
            r_locked     <= (r_state == RUN) && (w_state_next == RUN);
            r_user_rst_n <= (r_state == RUN) && (w_state_next == RUN);
            r_busy       <= !((w_state_next == RUN) || (w_state_next == FAIL));
            r_fail       <= (w_state_next == FAIL);
        end
    end

`ifdef PLL_DYN_CTRL_STATS_EN
    logic [7:0] r_relock_cnt;
    logic [1:0] r_last_err;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_relock_cnt <= '0;
            r_last_err   <= ERR_NONE;
        end else begin
            if (w_lock_loss && (r_relock_cnt != 8'hFF))
                r_relock_cnt <= r_relock_cnt + 8'd1;
            if (w_timeout)
                r_last_err <= (w_state_next == FAIL) ? ERR_FAIL : ERR_TIMEOUT;
            else if (w_lock_loss)
                r_last_err <= ERR_LOCK_LOSS;
        end
    end

    assign relock_cnt = r_relock_cnt;
    assign last_err   = r_last_err;
`endif

    assign req_ready   = w_req_ready;
    assign pll_reset   = r_pll_reset;
    assign pll_reset_p = r_pll_reset;
    assign idsel       = r_idsel;
    assign fbdsel      = r_fbdsel;
    assign odsel       = r_odsel;
    assign locked      = r_locked;
    assign user_rst_n  = r_user_rst_n;
    assign busy        = r_busy;
    assign fail        = r_fail;

endmodule
